// File: rtl/instruction_fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage: state encoding,
// default parameters, PC legality check and saturating counter step.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int          DEFAULT_IMEM_WORDS = 256;

    // A PC is unusable when it is not word aligned or lies past the end of memory.
    function automatic logic pc_is_bad(input logic [31:0] pc, input logic [32:0] limit);
        logic misaligned;
        logic out_of_range;
        misaligned   = (pc[1:0] != 2'b00);
        out_of_range = ({1'b0, pc} >= limit);
        return misaligned || out_of_range;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the asynchronous instruction memory and
// presents {pc, instr} to decode through a valid/ready output register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    // Byte limit kept one bit wider so a large memory depth cannot wrap the compare.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_id_valid;
    logic         w_id_valid_nxt;
    logic [31:0]  r_id_pc;
    logic [31:0]  w_id_pc_nxt;
    logic [31:0]  r_id_instr;
    logic [31:0]  w_id_instr_nxt;
    logic [31:0]  r_id_pc_plus4;
    logic [31:0]  w_id_pc_plus4_nxt;
    logic         r_fault;
    logic         w_fault_nxt;
    logic [31:0]  r_count;
    logic [31:0]  w_count_nxt;

    logic [31:0]  w_pc_plus4;
    logic         w_pc_bad;
    logic         w_adv;
    logic         w_accept;

    // Sequential PC, legality of the current PC and handshake qualifiers.
    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        w_pc_bad   = pc_is_bad(r_pc, PC_LIMIT);
        w_adv      = !r_id_valid || id_ready;
        w_accept   = r_id_valid && id_ready;
    end

    // State register and all IF/ID output registers; reset values win over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH_IDLE;
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_pc       <= 32'd0;
            r_id_instr    <= 32'd0;
            r_id_pc_plus4 <= 32'd0;
            r_fault       <= 1'b0;
            r_count       <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
            r_fault       <= w_fault_nxt;
            r_count       <= w_count_nxt;
        end
    end

    // Next-state and next-output selection: redirect, then fault, then advance, else stall.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_id_valid_nxt    = r_id_valid;
        w_id_pc_nxt       = r_id_pc;
        w_id_instr_nxt    = r_id_instr;
        w_id_pc_plus4_nxt = r_id_pc_plus4;
        w_fault_nxt       = r_fault;

        case (r_state)
            FETCH_IDLE: begin
                w_state_nxt = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_id_valid_nxt = 1'b0;
                end else if (w_pc_bad) begin
                    w_state_nxt    = FETCH_FAULT;
                    w_fault_nxt    = 1'b1;
                    w_id_valid_nxt = 1'b0;
                end else if (w_adv) begin
                    w_id_valid_nxt    = 1'b1;
                    w_id_pc_nxt       = r_pc;
                    w_id_instr_nxt    = imem_instr;
                    w_id_pc_plus4_nxt = w_pc_plus4;
                    w_pc_nxt          = w_pc_plus4;
                end else begin
                    w_id_valid_nxt = r_id_valid;
                end
            end
            FETCH_FAULT: begin
                w_id_valid_nxt = 1'b0;
            end
            default: begin
                // Corrupted state encoding is treated as a fault rather than guessed at.
                w_state_nxt    = FETCH_FAULT;
                w_fault_nxt    = 1'b1;
                w_id_valid_nxt = 1'b0;
            end
        endcase

        if (w_accept) begin
            w_count_nxt = sat_inc32(r_count);
        end else begin
            w_count_nxt = r_count;
        end
    end

    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_instr    = r_id_instr;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign fetch_fault = r_fault;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory (word n = 32'h1000_0000+n),
// a scoreboard of expected accepted instructions, and per-scenario checks.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   total = 0;
    int   bad   = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(256)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h1000_0000 + {2'b00, pc[31:2]};
        return e;
    endfunction

    task automatic push(input logic [31:0] pc);
        exp_q.push_back(mk(pc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic rdy);
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick();
        rst = 1'b0; id_ready = rdy;
    endtask

    // Handshake monitor: every accepted instruction must match the next expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no handshake", id_pc, id_instr);
            end else begin
                sb_e = exp_q.pop_front();
                if (id_pc !== sb_e.pc || id_instr !== sb_e.instr || id_pc_plus4 !== sb_e.pc + 32'd4) begin
                    bad++;
                    $display("FAIL sb_item: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                             id_pc, id_instr, id_pc_plus4, sb_e.pc, sb_e.instr, sb_e.pc + 32'd4);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", id_valid); end
        total++; if (id_pc !== 32'd0 || id_instr !== 32'd0 || id_pc_plus4 !== 32'd0) begin
            bad++; $display("FAIL reset_id: got pc=%h instr=%h pc4=%h required zeros", id_pc, id_instr, id_pc_plus4); end
        total++; if (fetch_fault !== 1'b0 || fetch_count !== 32'd0) begin
            bad++; $display("FAIL reset_status: got fault=%b count=%0d required 0/0", fetch_fault, fetch_count); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
    endtask

    task automatic test_stream();
        push(32'd0); push(32'd4); push(32'd8);
        start(1'b1);
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stream_bubble: got valid=%b required 0", id_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_instr !== 32'h1000_0000 + 32'(i)) begin
                bad++; $display("FAIL stream_item%0d: got v=%b pc=%h instr=%h required pc=%h instr=%h",
                                i, id_valid, id_pc, id_instr, 32'(i * 4), 32'h1000_0000 + 32'(i));
            end
        end
        tick();
        id_ready = 1'b0;
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stream_count: got %0d required 3", fetch_count); end
        total++; if (id_pc !== 32'd12) begin bad++; $display("FAIL stream_next: got pc=%h required c", id_pc); end
    endtask

    task automatic run_to_stall8();
        push(32'd0); push(32'd4);
        start(1'b1);
        repeat (4) tick();
        id_ready = 1'b0;
    endtask

    task automatic test_stall();
        run_to_stall8();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (id_valid !== 1'b1 || id_pc !== 32'd8 || id_instr !== 32'h1000_0002 || imem_addr !== 32'd12) begin
                bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h required 1/8/10000002/c",
                                i, id_valid, id_pc, id_instr, imem_addr);
            end
        end
        push(32'd8);
        id_ready = 1'b1;
        tick();
        total++; if (id_pc !== 32'd12 || id_instr !== 32'h1000_0003) begin
            bad++; $display("FAIL stall_release: got pc=%h instr=%h required c/10000003", id_pc, id_instr); end
    endtask

    task automatic test_redirect();
        run_to_stall8();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        total++; if (id_valid !== 1'b0 || imem_addr !== 32'h40) begin
            bad++; $display("FAIL redir_kill: got v=%b addr=%h required 0/40", id_valid, imem_addr); end
        push(32'h40);
        id_ready = 1'b1;
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h1000_0010 || id_pc_plus4 !== 32'h44) begin
            bad++; $display("FAIL redir_target: got v=%b pc=%h instr=%h pc4=%h required 1/40/10000010/44",
                            id_valid, id_pc, id_instr, id_pc_plus4); end
        // Redirect in the same cycle decode consumes: the consumed item still counts.
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        total++; if (id_valid !== 1'b0 || fetch_count !== 32'd3 || imem_addr !== 32'h80) begin
            bad++; $display("FAIL redir_accept: got v=%b count=%0d addr=%h required 0/3/80", id_valid, fetch_count, imem_addr); end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        total++; if (fetch_fault !== 1'b0 || imem_addr !== 32'h42) begin
            bad++; $display("FAIL fault_early: got fault=%b addr=%h required 0/42", fetch_fault, imem_addr); end
        tick();
        total++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0) begin
            bad++; $display("FAIL fault_set: got fault=%b v=%b required 1/0", fetch_fault, id_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(); tick();
        redirect_valid = 1'b0;
        total++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'h42 || fetch_count !== 32'd3) begin
            bad++; $display("FAIL fault_sticky: got fault=%b v=%b addr=%h count=%0d required 1/0/42/3",
                            fetch_fault, id_valid, imem_addr, fetch_count); end
    endtask

    task automatic test_range_end();
        for (int n = 0; n < 256; n++) push(32'(n * 4));
        start(1'b1);
        for (int i = 0; i < 400 && fetch_fault !== 1'b1; i++) tick();
        total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL range_timeout: got fault=%b required 1", fetch_fault); end
        total++; if (id_pc !== 32'h3FC || imem_addr !== 32'h400 || id_valid !== 1'b0) begin
            bad++; $display("FAIL range_last: got pc=%h addr=%h v=%b required 3fc/400/0", id_pc, imem_addr, id_valid); end
        total++; if (fetch_count !== 32'd256 || exp_q.size() != 0) begin
            bad++; $display("FAIL range_count: got count=%0d pending=%0d required 256/0", fetch_count, exp_q.size()); end
    endtask

    task automatic test_reset_midstall();
        push(32'd0); push(32'd4); push(32'd8); push(32'd12); push(32'd16);
        start(1'b1);
        repeat (7) tick();
        id_ready = 1'b0;
        tick();
        total++; if (fetch_count !== 32'd5 || id_pc !== 32'd20 || id_valid !== 1'b1) begin
            bad++; $display("FAIL rst_pre: got count=%0d pc=%h v=%b required 5/14/1", fetch_count, id_pc, id_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== 32'd0 || id_pc_plus4 !== 32'd0 ||
                     fetch_count !== 32'd0 || fetch_fault !== 1'b0 || imem_addr !== 32'd0) begin
            bad++; $display("FAIL rst_mid: got v=%b pc=%h instr=%h pc4=%h count=%0d fault=%b addr=%h required all zero",
                            id_valid, id_pc, id_instr, id_pc_plus4, fetch_count, fetch_fault, imem_addr); end
        push(32'd0);
        id_ready = 1'b1;
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_bubble: got v=%b required 0", id_valid); end
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_instr !== 32'h1000_0000) begin
            bad++; $display("FAIL rst_restart: got v=%b pc=%h instr=%h required 1/0/10000000", id_valid, id_pc, id_instr); end
        tick();
        id_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault();
        test_range_end();
        test_reset_midstall();
        tick();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: got pending=%0d required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
